// File: rtl/vx_lru_table.sv
// vx_lru_table: per-set true-LRU replacement table (order stack + valid mask).
// Sets are initialised after reset; requests get a one-cycle response.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   req_valid/req_ready   request handshake (ready only after init sweep)
//   req_op                0=TOUCH 1=FILL 2=INVAL 3=FLUSH_SET
//   req_set, req_way      target set / way
//   rsp_valid             strobe, one cycle after acceptance
//   rsp_way, rsp_err      affected way (FILL: victim), TOUCH-invalid flag
//   set_full              all ways of req_set valid (current state)
module vx_lru_table #(
    parameter int NUM_SETS = 16,
    parameter int NUM_WAYS = 4,
    localparam int SET_SEL_W = $clog2(NUM_SETS),
    localparam int WAY_SEL_W = $clog2(NUM_WAYS)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [1:0]           req_op,
    input  logic [SET_SEL_W-1:0] req_set,
    input  logic [WAY_SEL_W-1:0] req_way,
    output logic                 rsp_valid,
    output logic [WAY_SEL_W-1:0] rsp_way,
    output logic                 rsp_err,
    output logic                 set_full
);

    localparam logic [1:0] OP_TOUCH = 2'd0;
    localparam logic [1:0] OP_FILL  = 2'd1;
    localparam logic [1:0] OP_INVAL = 2'd2;
    localparam logic [1:0] OP_FLUSH = 2'd3;

    typedef logic [NUM_WAYS-1:0][WAY_SEL_W-1:0] order_t;
    typedef enum logic {INIT, READY} state_t;

    // slot 0 = LRU, slot NUM_WAYS-1 = MRU
    order_t              order_q [NUM_SETS];
    logic [NUM_WAYS-1:0] valid_q [NUM_SETS];

    state_t               state_q;
    state_t               state_nxt;
    logic [SET_SEL_W-1:0] init_cnt;
    logic                 init_wr;
    logic                 accept;

    order_t               ident;
    order_t               cur_order;
    logic [NUM_WAYS-1:0]  cur_valid;
    logic [WAY_SEL_W-1:0] victim;
    logic [WAY_SEL_W-1:0] tgt;
    logic [WAY_SEL_W-1:0] pos;
    order_t               mru_order;
    order_t               lru_order;

    order_t               nxt_order;
    logic [NUM_WAYS-1:0]  nxt_valid;
    logic [WAY_SEL_W-1:0] nxt_way;
    logic                 nxt_err;
    logic                 upd_en;

    // ---------------- FSM ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= INIT;
            init_cnt <= '0;
        end else begin
            state_q <= state_nxt;
            if (init_wr) init_cnt <= init_cnt + 1'b1;
        end
    end

    always_comb begin
        state_nxt = state_q;
        unique case (state_q)
            INIT:  if (init_cnt == SET_SEL_W'(NUM_SETS - 1)) state_nxt = READY;
            READY: state_nxt = READY;
        endcase
    end

    always_comb begin
        req_ready = (state_q == READY);
        init_wr   = (state_q == INIT) && !reset;
    end

    assign accept = req_valid && req_ready && !reset;

    // ---------------- set lookup ----------------
    always_comb begin
        for (int i = 0; i < NUM_WAYS; i++) ident[i] = WAY_SEL_W'(i);
    end

    assign cur_order = order_q[req_set];
    assign cur_valid = valid_q[req_set];
    assign set_full  = &cur_valid;

    // Scan from the top so the lowest-index invalid way wins.
    always_comb begin
        victim = cur_order[0];
        for (int i = NUM_WAYS - 1; i >= 0; i--) begin
            if (!cur_valid[i]) victim = WAY_SEL_W'(i);
        end
    end

    assign tgt = (req_op == OP_FILL) ? victim : req_way;

    always_comb begin
        pos = '0;
        for (int i = 0; i < NUM_WAYS; i++) begin
            if (cur_order[i] == tgt) pos = WAY_SEL_W'(i);
        end
    end

    // Promote tgt to MRU: entries above its old slot slide down.
    always_comb begin
        mru_order = cur_order;
        for (int i = 0; i < NUM_WAYS - 1; i++) begin
            if (WAY_SEL_W'(i) >= pos) mru_order[i] = cur_order[i+1];
        end
        mru_order[NUM_WAYS-1] = tgt;
    end

    // Demote tgt to LRU: entries below its old slot slide up.
    always_comb begin
        lru_order = cur_order;
        for (int i = 1; i < NUM_WAYS; i++) begin
            if (WAY_SEL_W'(i) <= pos) lru_order[i] = cur_order[i-1];
        end
        lru_order[0] = tgt;
    end

    always_comb begin
        nxt_order = cur_order;
        nxt_valid = cur_valid;
        nxt_way   = req_way;
        nxt_err   = 1'b0;
        upd_en    = 1'b1;
        unique case (req_op)
            OP_TOUCH: begin
                if (cur_valid[req_way]) begin
                    nxt_order = mru_order;
                end else begin
                    nxt_err = 1'b1;
                    upd_en  = 1'b0;
                end
            end
            OP_FILL: begin
                nxt_order         = mru_order;
                nxt_valid[victim] = 1'b1;
                nxt_way           = victim;
            end
            OP_INVAL: begin
                nxt_order          = lru_order;
                nxt_valid[req_way] = 1'b0;
            end
            OP_FLUSH: begin
                nxt_order = ident;
                nxt_valid = '0;
                nxt_way   = '0;
            end
        endcase
    end

    // ---------------- storage ----------------
    // Single write port: the init sweep and requests never overlap.
    always_ff @(posedge clk) begin
        if (init_wr) begin
            order_q[init_cnt] <= ident;
            valid_q[init_cnt] <= '0;
        end else if (accept && upd_en) begin
            order_q[req_set] <= nxt_order;
            valid_q[req_set] <= nxt_valid;
        end
    end

    // ---------------- response ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            rsp_valid <= 1'b0;
            rsp_way   <= '0;
            rsp_err   <= 1'b0;
        end else begin
            rsp_valid <= accept;
            if (accept) begin
                rsp_way <= nxt_way;
                rsp_err <= nxt_err;
            end else begin
                rsp_err <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_vx_lru_table.sv
// tb_vx_lru_table: scoreboard bench for vx_lru_table (4 sets x 4 ways).
// Queue-based reference model, directed cases, then random traffic.
module tb_vx_lru_table;

    localparam int NS = 4;
    localparam int NW = 4;
    localparam int SW = $clog2(NS);
    localparam int WW = $clog2(NW);

    localparam int T_TOUCH = 0;
    localparam int T_FILL  = 1;
    localparam int T_INVAL = 2;
    localparam int T_FLUSH = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic          req_valid;
    logic          req_ready;
    logic [1:0]    req_op;
    logic [SW-1:0] req_set;
    logic [WW-1:0] req_way;
    logic          rsp_valid;
    logic [WW-1:0] rsp_way;
    logic          rsp_err;
    logic          set_full;

    vx_lru_table #(.NUM_SETS(NS), .NUM_WAYS(NW)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_set   (req_set),
        .req_way   (req_way),
        .rsp_valid (rsp_valid),
        .rsp_way   (rsp_way),
        .rsp_err   (rsp_err),
        .set_full  (set_full)
    );

    always #5 clk = ~clk;

    typedef struct {
        int way;
        int err;
    } rsp_t;

    rsp_t exp_q[$];
    int   n_pass = 0;
    int   n_total = 0;

    // Reference model: each set is a list, front = LRU, back = MRU.
    int      ord [NS][$];
    bit [NW-1:0] vld [NS];

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    function automatic void m_reset_set(input int s);
        ord[s].delete();
        for (int i = 0; i < NW; i++) ord[s].push_back(i);
        vld[s] = '0;
    endfunction

    function automatic void m_reset();
        for (int s = 0; s < NS; s++) m_reset_set(s);
    endfunction

    function automatic int m_find(input int s, input int w);
        for (int i = 0; i < ord[s].size(); i++) if (ord[s][i] == w) return i;
        return -1;
    endfunction

    function automatic void m_to_mru(input int s, input int w);
        ord[s].delete(m_find(s, w));
        ord[s].push_back(w);
    endfunction

    function automatic void m_to_lru(input int s, input int w);
        ord[s].delete(m_find(s, w));
        ord[s].push_front(w);
    endfunction

    function automatic void m_apply(input int op, input int s, input int w,
                                    output int ew, output int ee);
        int v;
        ew = w;
        ee = 0;
        case (op)
            T_TOUCH: begin
                if (vld[s][w]) m_to_mru(s, w);
                else ee = 1;
            end
            T_FILL: begin
                v = -1;
                for (int i = NW - 1; i >= 0; i--) if (!vld[s][i]) v = i;
                if (v < 0) v = ord[s][0];
                vld[s][v] = 1'b1;
                m_to_mru(s, v);
                ew = v;
            end
            T_INVAL: begin
                vld[s][w] = 1'b0;
                m_to_lru(s, w);
            end
            default: begin
                m_reset_set(s);
                ew = 0;
            end
        endcase
    endfunction

    // Monitor: pops one expectation per response strobe.
    initial begin
        rsp_t e;
        forever begin
            @(negedge clk);
            if (rsp_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_rsp", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("rsp_way", int'(rsp_way), e.way);
                    chk("rsp_err", int'(rsp_err), e.err);
                end
            end
        end
    end

    // Called at posedge+1; leaves req_valid high for back-to-back use.
    task automatic do_req(input int op, input int s, input int w,
                          input int xw, input int xe);
        int   n = 0;
        int   ew, ee;
        rsp_t r;
        bit [NW-1:0] seen;
        while (!req_ready && n < 50) begin
            req_valid = 1'b0;
            @(posedge clk); #1;
            n++;
        end
        if (!req_ready) begin
            chk("ready_timeout", 0, 1);
            return;
        end
        req_valid = 1'b1;
        req_op    = 2'(op);
        req_set   = SW'(s);
        req_way   = WW'(w);
        #1;
        chk("set_full", int'(set_full), int'(&vld[s]));
        m_apply(op, s, w, ew, ee);
        r.way = (xw >= 0) ? xw : ew;
        r.err = (xe >= 0) ? xe : ee;
        exp_q.push_back(r);
        @(posedge clk); #1;
        seen = '0;
        for (int i = 0; i < NW; i++) seen[dut.order_q[s][i]] = 1'b1;
        chk("perm", int'(seen), (1 << NW) - 1);
    endtask

    task automatic idle();
        req_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic rsp_zero_chk();
        chk("rst_rsp_valid", int'(rsp_valid), 0);
        chk("rst_rsp_err", int'(rsp_err), 0);
        chk("rst_rsp_way", int'(rsp_way), 0);
        chk("rst_ready", int'(req_ready), 0);
    endtask

    task automatic ready_after_release();
        chk("init_ready_0", int'(req_ready), 0);
        for (int i = 1; i <= NS; i++) begin
            @(posedge clk); #1;
            chk("init_ready", int'(req_ready), (i == NS) ? 1 : 0);
        end
    endtask

    initial begin
        int op, s, w, r;
        reset     = 1'b1;
        req_valid = 1'b0;
        req_op    = '0;
        req_set   = '0;
        req_way   = '0;
        @(posedge clk); #1;
        rsp_zero_chk();
        reset = 1'b0;
        ready_after_release();

        // Reset again two cycles into the init sweep.
        reset = 1'b1;
        @(posedge clk); #1;
        rsp_zero_chk();
        reset = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
        end
        chk("mid_init_ready", int'(req_ready), 0);
        reset = 1'b1;
        @(posedge clk); #1;
        rsp_zero_chk();
        reset = 1'b0;
        ready_after_release();
        m_reset();

        // Directed sequence (back-to-back where adjacent).
        do_req(T_FILL, 0, 0, 0, 0);
        do_req(T_FILL, 0, 0, 1, 0);
        do_req(T_FILL, 0, 0, 2, 0);
        do_req(T_FILL, 0, 0, 3, 0);
        idle();
        chk("set_full_set0", int'(set_full), 1);
        do_req(T_FILL, 1, 0, 0, 0);
        do_req(T_TOUCH, 0, 0, 0, 0);
        do_req(T_FILL, 0, 0, 1, 0);
        do_req(T_TOUCH, 0, 2, 2, 0);
        do_req(T_FILL, 0, 0, 3, 0);
        do_req(T_INVAL, 0, 0, 0, 0);
        do_req(T_FILL, 0, 0, 0, 0);
        do_req(T_FLUSH, 0, 0, 0, 0);
        do_req(T_TOUCH, 0, 1, 1, 1);
        do_req(T_FILL, 0, 0, 0, 0);
        idle();

        // Random traffic against the model.
        for (int k = 0; k < 10000; k++) begin
            r  = $urandom_range(99);
            op = (r < 35) ? T_FILL : (r < 70) ? T_TOUCH : (r < 92) ? T_INVAL : T_FLUSH;
            s  = $urandom_range(NS - 1);
            w  = $urandom_range(NW - 1);
            do_req(op, s, w, -1, -1);
            if ($urandom_range(7) == 0) idle();
        end
        idle();

        // Reset while a request is presented: no response may appear.
        req_valid = 1'b1;
        req_op    = 2'(T_FILL);
        req_set   = '0;
        reset     = 1'b1;
        @(posedge clk); #1;
        chk("rst_drop_rsp", int'(rsp_valid), 0);
        req_valid = 1'b0;
        reset     = 1'b0;
        ready_after_release();
        m_reset();
        do_req(T_FILL, 0, 0, 0, 0);
        idle();
        repeat (3) idle();
        chk("queue_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
